// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: MMU instruction channel, back-end redirect and the dual-issue decode port.
// The master modport is the queue's own view; slave is the surrounding MMU/decode environment.
interface inst_fetch_queue_if;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ok;
  logic        inst_ok_1;
  logic        inst_ok_2;
  logic [31:0] inst_data_1;
  logic [31:0] inst_data_2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_cnt;
  logic        out0_valid;
  logic        out1_valid;
  logic [31:0] out0_inst;
  logic [31:0] out1_inst;
  logic [31:0] out0_pc;
  logic [31:0] out1_pc;
  logic        queue_empty;

  modport master (
    output inst_en, inst_addr,
    input  inst_ok, inst_ok_1, inst_ok_2, inst_data_1, inst_data_2,
    input  redirect, redirect_pc, deq_cnt,
    output out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, queue_empty
  );

  modport slave (
    input  inst_en, inst_addr,
    output inst_ok, inst_ok_1, inst_ok_2, inst_data_1, inst_data_2,
    output redirect, redirect_pc, deq_cnt,
    input  out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, queue_empty
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding MMU request, up to two words pushed per response,
// decode drains up to two per cycle; 1-cycle response-to-decode latency, fetch stalls when space runs low.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = AW + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic          en_q;
  logic [31:0]   addr_q;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nx1;
  logic [AW-1:0] tail_nx1;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic          accept;
  logic          push_one;
  logic          push_two;
  logic          space_ok;
  logic [1:0]    push_n;
  logic [1:0]    pop_req;
  logic [1:0]    pop_n;
  logic [NW-1:0] next_count;
  logic [31:0]   pc_adv;
  logic          out0_v;
  logic          out1_v;

  always_comb begin
    accept     = (state == REQ) && bus.inst_ok && !bus.redirect;
    push_one   = accept && bus.inst_ok_1;
    push_two   = push_one && bus.inst_ok_2;
    push_n     = {push_two, push_one & ~push_two};
    pop_req    = (bus.deq_cnt == 2'd3) ? 2'd2 : bus.deq_cnt;
    pop_n      = (NW'(pop_req) > NW'(count)) ? count[1:0] : pop_req;
    next_count = NW'(count) + NW'(push_n) - NW'(pop_n);
    // Two free slots must remain for the response to the request being issued now.
    space_ok   = (next_count <= NW'(DEPTH - 2));
    pc_adv     = pc + (push_two ? 32'd8 : (push_one ? 32'd4 : 32'd0));
    head_nx1   = head + AW'(1);
    tail_nx1   = tail + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (push_one) begin
      mem_pc[tail]   <= addr_q;
      mem_inst[tail] <= bus.inst_data_1;
    end
    if (push_two) begin
      mem_pc[tail_nx1]   <= addr_q + 32'd4;
      mem_inst[tail_nx1] <= bus.inst_data_2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      en_q   <= 1'b0;
      addr_q <= 32'd0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      pc    <= bus.redirect_pc;
      head  <= tail;
      count <= '0;
      // An unanswered request cannot be withdrawn, so keep presenting it and discard its answer.
      if ((state == REQ || state == DROP) && !bus.inst_ok) begin
        state <= DROP;
      end else begin
        state <= IDLE;
        en_q  <= 1'b0;
      end
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= next_count[CW-1:0];
      case (state)
        IDLE: begin
          if (space_ok) begin
            state  <= REQ;
            en_q   <= 1'b1;
            addr_q <= pc;
          end
        end
        REQ: begin
          if (bus.inst_ok) begin
            pc <= pc_adv;
            if (space_ok) begin
              addr_q <= pc_adv;
            end else begin
              state <= IDLE;
              en_q  <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.inst_ok) begin
            state <= IDLE;
            en_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out0_v          = (count != '0);
  assign out1_v          = (count > CW'(1));
  assign bus.inst_en     = en_q;
  assign bus.inst_addr   = addr_q;
  assign bus.out0_valid  = out0_v;
  assign bus.out1_valid  = out1_v;
  assign bus.out0_pc     = out0_v ? mem_pc[head]       : 32'd0;
  assign bus.out0_inst   = out0_v ? mem_inst[head]     : 32'd0;
  assign bus.out1_pc     = out1_v ? mem_pc[head_nx1]   : 32'd0;
  assign bus.out1_inst   = out1_v ? mem_inst[head_nx1] : 32'd0;
  assign bus.queue_empty = !out0_v;

endmodule
